// File: rtl/ndp_host_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ndp_host_pkg
// Brief    : Shared types and constants for the NDP stream host.
// Revision : 1.0 - initial release
// ============================================================================
package ndp_host_pkg;

    localparam int c_addr_w    = 12;
    localparam int c_len_w     = 12;
    localparam int c_res_words = 512;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_STREAM   = 3'd2,
        S_WAIT_RES = 3'd3,
        S_COLLECT  = 3'd4,
        S_DONE     = 3'd5
    } ndp_host_state_t;

    typedef struct packed {
        logic [c_addr_w-1:0] src_base;
        logic [c_len_w-1:0]  len;
        logic [c_addr_w-1:0] res_base;
        logic                is_relu;
        logic                is_last;
    } ndp_cmd_t;

endpackage
`default_nettype wire

// File: rtl/ndp_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ndp_skid_fifo
// Brief    : 2-entry data+last FIFO that also accounts for one in-flight
//            source read (1-cycle RAM latency) when granting new reads.
// Revision : 1.0 - initial release
// ============================================================================
module ndp_skid_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue,
    input  logic        issue_last,
    input  logic [31:0] rd_data,
    output logic        can_issue,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_ready
);

    logic [1:0][32:0] r_mem;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_cnt;
    logic             r_pend;
    logic             r_pend_last;
    logic             w_pop;
    logic [1:0]       w_occ;

    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_mem[r_rd_ptr][31:0];
    assign out_last  = r_mem[r_rd_ptr][32];
    assign w_pop     = out_valid & out_ready;

    // Occupancy net of the word leaving this cycle keeps one read per cycle
    // flowing while the consumer is ready.
    assign w_occ     = r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
    assign can_issue = ~w_occ[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem       <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_cnt       <= 2'd0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_pend      <= issue;
            r_pend_last <= issue_last;
            if (r_pend) begin
                r_mem[r_wr_ptr] <= {r_pend_last, rd_data};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ndp_stream_host.sv
`default_nettype none
// ============================================================================
// Module   : ndp_stream_host
// Brief    : Host-side AXI4-Stream feeder/collector for the NDP core.
// Config   : NDP_STREAM_HOST_PERF_EN adds stream/stall/wait cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module ndp_stream_host
    import ndp_host_pkg::*;
#(
    parameter int ADDR_W    = c_addr_w,
    parameter int LEN_W     = c_len_w,
    parameter int RES_WORDS = c_res_words
) (
    input  logic              axi_aclk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_res_base,
    input  logic              cmd_is_relu,
    input  logic              cmd_is_last,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic [31:0]       res_wr_data,
    output logic              is_relu_out,
    output logic              is_last_out,
    output logic              read_trigger_out,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              done_pulse,
`ifdef NDP_STREAM_HOST_PERF_EN
    output logic [31:0]       perf_stream_cycles,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_wait_cycles,
`endif
    output logic              err_tlast
);

    localparam int c_k_w = $clog2(RES_WORDS + 1);

    ndp_host_state_t  r_state;
    ndp_host_state_t  w_next;
    ndp_cmd_t         r_cmd;
    logic [LEN_W-1:0] r_rd_idx;
    logic [c_k_w-1:0] r_res_k;
    logic             r_trig;
    logic             r_err;
    logic             r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]      r_wr_data;

    logic             w_accept;
    logic [LEN_W-1:0] w_len_eff;
    logic             w_can_issue;
    logic             w_issue;
    logic             w_issue_last;
    logic             w_fifo_valid;
    logic [31:0]      w_fifo_data;
    logic             w_fifo_last;
    logic             w_m_xfer;
    logic             w_s_xfer;
    logic             w_k_last;

    assign cmd_ready     = (r_state == S_IDLE);
    assign s_axis_tready = (r_state == S_WAIT_RES) || (r_state == S_COLLECT);
    assign done_pulse    = (r_state == S_DONE);
    assign w_accept      = cmd_valid & cmd_ready;

    assign w_len_eff    = (r_cmd.len == '0) ? LEN_W'(1) : r_cmd.len;
    assign w_issue      = (r_state == S_STREAM) && (r_rd_idx != w_len_eff) && w_can_issue;
    assign w_issue_last = (r_rd_idx == w_len_eff - LEN_W'(1));
    assign w_m_xfer     = w_fifo_valid & m_axis_tready;
    assign w_s_xfer     = s_axis_tvalid & s_axis_tready;
    assign w_k_last     = (r_res_k == c_k_w'(RES_WORDS - 1));

    assign mem_rd_en        = w_issue;
    assign mem_rd_addr      = r_cmd.src_base + ADDR_W'(r_rd_idx);
    assign m_axis_tvalid    = w_fifo_valid;
    assign m_axis_tdata     = w_fifo_data;
    assign m_axis_tlast     = w_fifo_last;
    assign is_relu_out      = r_cmd.is_relu;
    assign is_last_out      = r_cmd.is_last;
    assign read_trigger_out = r_trig;
    assign err_tlast        = r_err;
    assign res_wr_en        = r_wr_en;
    assign res_wr_addr      = r_wr_addr;
    assign res_wr_data      = r_wr_data;

    ndp_skid_fifo u_fifo (
        .clk        (axi_aclk),
        .rst        (reset),
        .issue      (w_issue),
        .issue_last (w_issue_last),
        .rd_data    (mem_rd_data),
        .can_issue  (w_can_issue),
        .out_valid  (w_fifo_valid),
        .out_data   (w_fifo_data),
        .out_last   (w_fifo_last),
        .out_ready  (m_axis_tready)
    );

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_next = S_ARM;
            S_ARM:      w_next = S_STREAM;
            S_STREAM:   if (w_m_xfer && w_fifo_last) w_next = r_cmd.is_last ? S_WAIT_RES : S_DONE;
            S_WAIT_RES: if (w_s_xfer) w_next = w_k_last ? S_DONE : S_COLLECT;
            S_COLLECT:  if (w_s_xfer && w_k_last) w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_cmd     <= '0;
            r_rd_idx  <= '0;
            r_res_k   <= '0;
            r_trig    <= 1'b0;
            r_err     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            if (w_accept) begin
                r_cmd.src_base <= cmd_src_base;
                r_cmd.len      <= cmd_len;
                r_cmd.res_base <= cmd_res_base;
                r_cmd.is_relu  <= cmd_is_relu;
                r_cmd.is_last  <= cmd_is_last;
                r_rd_idx       <= '0;
                r_res_k        <= '0;
            end
            if (w_issue) begin
                r_rd_idx <= r_rd_idx + LEN_W'(1);
            end
            // Flags are already stable by ARM; the core sees one edge per pass.
            if (r_state == S_ARM) begin
                r_trig <= ~r_trig;
            end
            r_wr_en <= w_s_xfer;
            if (w_s_xfer) begin
                r_wr_addr <= r_cmd.res_base + ADDR_W'(r_res_k);
                r_wr_data <= s_axis_tdata;
                r_res_k   <= r_res_k + c_k_w'(1);
                if (s_axis_tlast != w_k_last) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

`ifdef NDP_STREAM_HOST_PERF_EN
    logic [31:0] r_perf_stream;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_wait;

    assign perf_stream_cycles = r_perf_stream;
    assign perf_stall_cycles  = r_perf_stall;
    assign perf_wait_cycles   = r_perf_wait;

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_perf_stream <= '0;
            r_perf_stall  <= '0;
            r_perf_wait   <= '0;
        end else if (w_accept) begin
            r_perf_stream <= '0;
            r_perf_stall  <= '0;
            r_perf_wait   <= '0;
        end else begin
            if ((r_state == S_STREAM) && (r_perf_stream != '1)) begin
                r_perf_stream <= r_perf_stream + 32'd1;
            end
            if (w_fifo_valid && !m_axis_tready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if ((r_state == S_WAIT_RES) && (r_perf_wait != '1)) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ndp_stream_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_ndp_stream_host
// Brief    : Scoreboard bench for ndp_stream_host (stream out, result in).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ndp_stream_host;

    logic        axi_aclk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_src_base = '0;
    logic [11:0] cmd_len = '0;
    logic [11:0] cmd_res_base = '0;
    logic        cmd_is_relu = 1'b0;
    logic        cmd_is_last = 1'b0;
    logic        mem_rd_en;
    logic [11:0] mem_rd_addr;
    logic [31:0] mem_rd_data = '0;
    logic        res_wr_en;
    logic [11:0] res_wr_addr;
    logic [31:0] res_wr_data;
    logic        is_relu_out;
    logic        is_last_out;
    logic        read_trigger_out;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        done_pulse;
    logic        err_tlast;

    ndp_stream_host dut (
        .axi_aclk         (axi_aclk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_src_base     (cmd_src_base),
        .cmd_len          (cmd_len),
        .cmd_res_base     (cmd_res_base),
        .cmd_is_relu      (cmd_is_relu),
        .cmd_is_last      (cmd_is_last),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_data      (mem_rd_data),
        .res_wr_en        (res_wr_en),
        .res_wr_addr      (res_wr_addr),
        .res_wr_data      (res_wr_data),
        .is_relu_out      (is_relu_out),
        .is_last_out      (is_last_out),
        .read_trigger_out (read_trigger_out),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .done_pulse       (done_pulse),
        .err_tlast        (err_tlast)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct packed { logic last; logic [31:0] data; } beat_t;
    typedef struct packed { logic [11:0] addr; logic [31:0] data; } wr_t;

    beat_t exp_beats[$];
    wr_t   exp_wr[$];
    int    checks = 0;
    int    errors = 0;
    int    m_beats = 0;
    int    done_cnt = 0;
    int    trig_changes = 0;
    int    tr_mode = 0;
    logic  exp_relu = 1'b0;
    logic  exp_last = 1'b0;
    logic  exp_trig = 1'b0;
    logic  flag_en = 1'b0;
    logic  hold_v = 1'b0;
    logic [32:0] hold_d = '0;
    logic  prev_done = 1'b0;
    logic  prev_trig = 1'b0;
    beat_t b;
    wr_t   w;

    function automatic logic [31:0] src_word(input logic [11:0] a);
        return 32'hA500_0000 ^ {4'h0, a, 4'h0, a};
    endfunction

    // Source RAM model: data one cycle after the read strobe.
    always @(posedge axi_aclk) begin
        if (mem_rd_en) mem_rd_data <= src_word(mem_rd_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge axi_aclk) begin
        if (reset) begin
            hold_v    = 1'b0;
            prev_done = 1'b0;
            prev_trig = read_trigger_out;
        end else begin
            if (hold_v)
                check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, hold_d});
            hold_v = m_axis_tvalid & ~m_axis_tready;
            hold_d = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_beats.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", m_axis_tdata);
                end else begin
                    b = exp_beats.pop_front();
                    check("m_beat", {m_axis_tlast, m_axis_tdata}, b);
                end
                m_beats++;
            end
            if (res_wr_en) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write actual=%0h required=none", res_wr_addr);
                end else begin
                    w = exp_wr.pop_front();
                    check("res_write", {res_wr_addr, res_wr_data}, w);
                end
            end
            if (done_pulse && prev_done) begin
                checks++; errors++;
                $display("FAIL done_width actual=2 required=1");
            end
            if (done_pulse) done_cnt++;
            prev_done = done_pulse;
            if (read_trigger_out !== prev_trig) trig_changes++;
            prev_trig = read_trigger_out;
            if (flag_en) check("flags", {is_relu_out, is_last_out}, {exp_relu, exp_last});
        end
    end

    initial begin
        forever begin
            @(posedge axi_aclk); #1;
            m_axis_tready = (tr_mode == 0) ? 1'b1 : ~m_axis_tready;
        end
    end

    task automatic issue_cmd(input logic [11:0] src, input logic [11:0] len, input logic [11:0] res,
                             input logic relu, input logic last);
        int n = 0;
        int eff;
        while (!cmd_ready && n < 3000) begin @(posedge axi_aclk); #1; n++; end
        check("cmd_ready_idle", cmd_ready, 1);
        eff = (len == 0) ? 1 : len;
        for (int i = 0; i < eff; i++) begin
            logic [11:0] a;
            a = src + i[11:0];
            exp_beats.push_back({(i == eff - 1), src_word(a)});
        end
        cmd_valid = 1'b1; cmd_src_base = src; cmd_len = len; cmd_res_base = res;
        cmd_is_relu = relu; cmd_is_last = last;
        @(posedge axi_aclk); #1;
        cmd_valid = 1'b0;
        exp_relu = relu; exp_last = last; flag_en = 1'b1; exp_trig = ~exp_trig;
        check("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin @(posedge axi_aclk); #1; n++; end
        check("done_seen", (done_cnt != start), 1);
    endtask

    task automatic send_results(input logic [11:0] res, input int tlast_pos);
        int d0 = done_cnt;
        for (int k = 0; k < 512; k++) begin
            int n = 0;
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge axi_aclk); #1; end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'h5EED_0000 + k;
            s_axis_tlast  = (k == tlast_pos);
            exp_wr.push_back({res + k[11:0], 32'h5EED_0000 + k});
            if (k == 511) check("no_early_done", done_cnt, d0);
            while (!s_axis_tready && n < 3000) begin @(posedge axi_aclk); #1; n++; end
            if (n >= 3000) check("res_handshake_timeout", n, 0);
            @(posedge axi_aclk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic end_of_pass(input int tc0);
        check("trigger", read_trigger_out, exp_trig);
        check("trig_toggles", trig_changes - tc0, 1);
        check("beats_drained", exp_beats.size(), 0);
        check("writes_drained", exp_wr.size(), 0);
    endtask

    initial begin
        int tc0;
        #900_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int tc0;
        int b0;
        int n;
        repeat (3) @(posedge axi_aclk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_outputs", {mem_rd_en, res_wr_en, is_relu_out, is_last_out, read_trigger_out,
                              m_axis_tvalid, m_axis_tlast, s_axis_tready, done_pulse, err_tlast}, 0);
        check("rst_buses", {mem_rd_addr, res_wr_addr, m_axis_tdata, res_wr_data}, 0);
        reset = 1'b0;
        @(posedge axi_aclk); #1;

        // Non-last pass, tready held high.
        tc0 = trig_changes;
        issue_cmd(12'h010, 12'd34, 12'h000, 1'b1, 1'b0);
        wait_done(500);
        end_of_pass(tc0);

        // Same pass with tready toggling; flags change at accept.
        tr_mode = 1;
        tc0 = trig_changes;
        issue_cmd(12'h010, 12'd34, 12'h000, 1'b0, 1'b0);
        wait_done(500);
        end_of_pass(tc0);
        tr_mode = 0;

        // Zero length behaves as one word.
        tc0 = trig_changes;
        issue_cmd(12'h7FF, 12'd0, 12'h000, 1'b1, 1'b0);
        wait_done(200);
        end_of_pass(tc0);

        // Final pass with source wrap, correct result tlast.
        tc0 = trig_changes;
        issue_cmd(12'hFF8, 12'd20, 12'h100, 1'b0, 1'b1);
        send_results(12'h100, 511);
        wait_done(200);
        end_of_pass(tc0);
        check("err_tlast_clean", err_tlast, 0);

        // Early result tlast; result address wraps past 0xFFF.
        tc0 = trig_changes;
        issue_cmd(12'h020, 12'd4, 12'hF00, 1'b1, 1'b1);
        send_results(12'hF00, 510);
        wait_done(200);
        end_of_pass(tc0);
        check("err_tlast_set", err_tlast, 1);

        // Reset in the middle of a stream.
        b0 = m_beats;
        issue_cmd(12'h040, 12'd34, 12'h000, 1'b0, 1'b0);
        n = 0;
        while (m_beats < b0 + 10 && n < 500) begin @(posedge axi_aclk); #1; n++; end
        check("reached_word10", m_beats - b0, 10);
        reset = 1'b1;
        #1;
        check("midrst_idle", {mem_rd_en, m_axis_tvalid, s_axis_tready, res_wr_en, done_pulse,
                              read_trigger_out, err_tlast}, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        exp_beats.delete();
        exp_wr.delete();
        exp_trig = 1'b0; exp_relu = 1'b0; exp_last = 1'b0;
        repeat (2) @(posedge axi_aclk);
        #1;
        reset = 1'b0;
        @(posedge axi_aclk); #1;

        tc0 = trig_changes;
        issue_cmd(12'h020, 12'd5, 12'h000, 1'b1, 1'b0);
        wait_done(200);
        end_of_pass(tc0);

        repeat (3) @(posedge axi_aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
